// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID sources, ID/EXE and EXE/MEM destinations,
// the EXE redirect, the stall/flush/bubble controls and debug counters.
// The master side is the pipeline; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int ASIZE = 5,
  parameter int CSIZE = 16
);
  logic [ASIZE-1:0] id_rs1;
  logic [ASIZE-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [ASIZE-1:0] idex_waddr;
  logic             idex_wen;
  logic             idex_memRead;
  logic [ASIZE-1:0] exmem_waddr;
  logic             exmem_wen;
  logic             exmem_memRead;
  logic             ex_redirect;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       busy_state;
  logic [CSIZE-1:0] stall_cnt;
  logic [CSIZE-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output idex_waddr, idex_wen, idex_memRead,
    output exmem_waddr, exmem_wen, exmem_memRead,
    output ex_redirect,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
    input  busy_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  idex_waddr, idex_wen, idex_memRead,
    input  exmem_waddr, exmem_wen, exmem_memRead,
    input  ex_redirect,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble,
    output busy_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Drives PC/IF-ID stall, IF-ID flush and ID-EXE bubble from the current
// operands/destinations and the EXE redirect, and keeps saturating
// stall/flush counters for performance debug.
// Build option: define FORWARD_EN when the EXE/MEM forwarding network is
// present; then only load-use against ID/EXE stalls. Otherwise any RAW
// against ID/EXE or EXE/MEM stalls.
module pipe_hazard_ctrl #(
  parameter int ASIZE = 5,
  parameter int CSIZE = 16
) (
  input logic                clk,
  input logic                rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             init_reg;
  logic [CSIZE-1:0] stall_cnt_reg;
  logic [CSIZE-1:0] flush_cnt_reg;

  // Producers in flight: index 0 is ID/EXE, index 1 is EXE/MEM.
  // MEM/WB is omitted because the register file writes before it reads.
  logic [ASIZE-1:0] prod_waddr [2];
  logic [1:0]       prod_wen;
  logic [1:0]       prod_hit;
  logic             haz;
  logic             unused_bits;

  logic pc_stall_c;
  logic ifid_stall_c;
  logic ifid_flush_c;
  logic idex_bubble_c;
  logic stall_evt;
  logic flush_evt;

  assign prod_waddr[0] = bus.idex_waddr;
  assign prod_waddr[1] = bus.exmem_waddr;
  assign prod_wen      = {bus.exmem_wen, bus.idex_wen};

  // A producer hits when it writes a non-x0 register that ID actually reads.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_prod
      assign prod_hit[gi] = prod_wen[gi] && (prod_waddr[gi] != '0) &&
                            ((bus.id_use_rs1 && (bus.id_rs1 == prod_waddr[gi])) ||
                             (bus.id_use_rs2 && (bus.id_rs2 == prod_waddr[gi])));
    end
  endgenerate

`ifdef FORWARD_EN
  // Forwarding covers ALU results; only a load still in EXE must wait.
  assign haz         = prod_hit[0] & bus.idex_memRead;
  assign unused_bits = ^{prod_hit[1], bus.exmem_memRead};
`else
  // No forwarding: any pending write in EXE or MEM blocks the reader.
  assign haz         = |prod_hit;
  assign unused_bits = ^{bus.idex_memRead, bus.exmem_memRead};
`endif

  // Next state and pipeline controls; redirect beats hazard. During reset and
  // the first cycle after it, the pipe is held squashed and no events count.
  always_comb begin
    state_next    = RUN;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    if (rst || init_reg) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (bus.ex_redirect) begin
      state_next    = FLUSH;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      flush_evt     = 1'b1;
    end else if (haz) begin
      state_next    = STALL;
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_bubble_c = 1'b1;
      stall_evt     = 1'b1;
    end
  end

  // State register plus the one-cycle post-reset marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      init_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      init_reg  <= 1'b0;
    end
  end

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != {CSIZE{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_evt && (flush_cnt_reg != {CSIZE{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.pc_stall    = pc_stall_c;
  assign bus.ifid_stall  = ifid_stall_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.busy_state  = state_reg;
  assign bus.stall_cnt   = stall_cnt_reg;
  assign bus.flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan steps followed
// by randomized traffic, compared against a rule-level reference model.
// Two instances: default counters (16 bits) and narrow counters (4 bits).
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_hazard_ctrl_if #(.ASIZE(5), .CSIZE(16)) hif ();
  pipe_hazard_ctrl_if #(.ASIZE(5), .CSIZE(4))  sif ();

  pipe_hazard_ctrl #(.ASIZE(5), .CSIZE(16)) u_dut (.clk(clk), .rst(rst), .bus(hif.slave));
  pipe_hazard_ctrl #(.ASIZE(5), .CSIZE(4))  u_sat (.clk(clk), .rst(rst), .bus(sif.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus copies kept by the bench for the model.
  logic [4:0] t_rs1, t_rs2, t_iw, t_ew;
  logic       t_u1, t_u2, t_iwen, t_imr, t_ewen, t_emr, t_redir;

  // Reference model state.
  int exp_state;
  bit exp_init;
  int exp_stall16, exp_flush16, exp_stall4, exp_flush4;

  function automatic bit reads(input logic [4:0] x);
    return (x != 5'd0) && ((t_u1 && t_rs1 == x) || (t_u2 && t_rs2 == x));
  endfunction

  function automatic bit model_haz();
`ifdef FORWARD_EN
    return t_imr && t_iwen && reads(t_iw);
`else
    return (t_iwen && reads(t_iw)) || (t_ewen && reads(t_ew));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] iw, input logic iwen, input logic imr,
                       input logic [4:0] ew, input logic ewen, input logic emr,
                       input logic redir);
    rst = r;
    t_rs1 = rs1; t_u1 = u1; t_rs2 = rs2; t_u2 = u2;
    t_iw = iw; t_iwen = iwen; t_imr = imr;
    t_ew = ew; t_ewen = ewen; t_emr = emr; t_redir = redir;
    hif.id_rs1 = rs1; hif.id_use_rs1 = u1; hif.id_rs2 = rs2; hif.id_use_rs2 = u2;
    hif.idex_waddr = iw; hif.idex_wen = iwen; hif.idex_memRead = imr;
    hif.exmem_waddr = ew; hif.exmem_wen = ewen; hif.exmem_memRead = emr;
    hif.ex_redirect = redir;
    sif.id_rs1 = rs1; sif.id_use_rs1 = u1; sif.id_rs2 = rs2; sif.id_use_rs2 = u2;
    sif.idex_waddr = iw; sif.idex_wen = iwen; sif.idex_memRead = imr;
    sif.exmem_waddr = ew; sif.exmem_wen = ewen; sif.exmem_memRead = emr;
    sif.ex_redirect = redir;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare both instances against the model for the current cycle.
  task automatic check_all();
    bit e_pc, e_is, e_fl, e_bu;
    e_pc = 0; e_is = 0; e_fl = 0; e_bu = 0;
    if (rst || exp_init) begin
      e_fl = 1; e_bu = 1;
    end else if (t_redir) begin
      e_fl = 1; e_bu = 1;
    end else if (model_haz()) begin
      e_pc = 1; e_is = 1; e_bu = 1;
    end
    chk("pc_stall",    32'(hif.pc_stall),    32'(e_pc));
    chk("ifid_stall",  32'(hif.ifid_stall),  32'(e_is));
    chk("ifid_flush",  32'(hif.ifid_flush),  32'(e_fl));
    chk("idex_bubble", 32'(hif.idex_bubble), 32'(e_bu));
    chk("busy_state",  32'(hif.busy_state),  32'(exp_state));
    chk("stall_cnt",   32'(hif.stall_cnt),   32'(exp_stall16));
    chk("flush_cnt",   32'(hif.flush_cnt),   32'(exp_flush16));
    chk("sat_controls", 32'({sif.pc_stall, sif.ifid_stall, sif.ifid_flush, sif.idex_bubble}),
        32'({e_pc, e_is, e_fl, e_bu}));
    chk("sat_stall_cnt", 32'(sif.stall_cnt), 32'(exp_stall4));
    chk("sat_flush_cnt", 32'(sif.flush_cnt), 32'(exp_flush4));
  endtask

  // Advance the model across one clock edge using the held inputs.
  task automatic update_model();
    if (rst) begin
      exp_state = 0; exp_init = 1;
      exp_stall16 = 0; exp_flush16 = 0; exp_stall4 = 0; exp_flush4 = 0;
    end else if (exp_init) begin
      exp_state = 0; exp_init = 0;
    end else if (t_redir) begin
      exp_state = 2;
      if (exp_flush16 < 65535) exp_flush16++;
      if (exp_flush4 < 15) exp_flush4++;
    end else if (model_haz()) begin
      exp_state = 1;
      if (exp_stall16 < 65535) exp_stall16++;
      if (exp_stall4 < 15) exp_stall4++;
    end else begin
      exp_state = 0;
    end
  endtask

  // One transaction: settle, check, clock, and print a line.
  task automatic cycle(input string what);
    #1;
    check_all();
    $display("t=%0t %s rst=%0b redir=%0b haz=%0b ctl=%b%b%b%b state=%0d stall=%0d flush=%0d",
             $time, what, rst, t_redir, model_haz(), hif.pc_stall, hif.ifid_stall,
             hif.ifid_flush, hif.idex_bubble, hif.busy_state, hif.stall_cnt, hif.flush_cnt);
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("reset");
    cycle("reset");
    idle();
    cycle("post_reset");
  endtask

  initial begin
    errors = 0; checks = 0;
    exp_state = 0; exp_init = 1;
    exp_stall16 = 0; exp_flush16 = 0; exp_stall4 = 0; exp_flush4 = 0;
    // First edge under reset so registered outputs are defined.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    update_model();
    @(negedge clk);

    do_reset();

    // Load-use: one stall, then the load has moved on to EXE/MEM.
    drive(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("load_use");
    chk("lu_stall_cnt_after", 32'(hif.stall_cnt), 32'd1);
    chk("lu_state_after", 32'(hif.busy_state), 32'd1);
    drive(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    cycle("load_in_mem");

    // ALU RAW on rs2: producer in ID/EXE, then in EXE/MEM.
    drive(1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("alu_raw_ex");
    drive(1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    cycle("alu_raw_mem");
    idle();
    cycle("idle");

    // x0 destination never hazards.
    drive(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle("x0_load");
    chk("x0_no_stall", 32'(hif.pc_stall), 32'd0);

    // Redirect together with load-use: flush wins, stall_cnt unchanged.
    drive(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("redir_haz");
    chk("redir_state", 32'(hif.busy_state), 32'd2);
    cycle("redir_redir");
    idle();
    cycle("idle");

    // Saturation of the narrow counter from a fresh reset.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle("redir_burst");
    end
    chk("sat_flush_hold", 32'(sif.flush_cnt), 32'd15);
    chk("wide_flush_20", 32'(hif.flush_cnt), 32'd20);

    // Reset in the middle of a stall.
    drive(1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("stall_before_rst");
    do_reset();

    // Randomized traffic with small addresses to provoke matches.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) == 0));
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
